// File: rtl/delay_line_prog.sv
// rtl/delay_line_prog.sv - runtime-programmable WIDTH-bit delay line with tracked valid and fill gating.
// Optional build macro DELAY_FLUSH_EN: accepted delay changes refill the line and blank sig_out while busy.
module delay_line_prog #(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 5,
  localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             sig_in_valid,
  input  logic [DLY_W-1:0] dly,
  input  logic             dly_load,
  output logic [WIDTH-1:0] sig_out,
  output logic             sig_out_valid,
  output logic [DLY_W-1:0] dly_cur,
  output logic             busy,
  output logic             dly_err
);

  localparam int AW = $clog2(MAX_DELAY);

  typedef enum logic {FILL, RUN} state_t;

  logic [WIDTH:0]   buf_q [MAX_DELAY];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_cur_q, dly_cur_d;
  logic [WIDTH-1:0] sig_out_q, sig_out_d;
  logic             sig_out_valid_q, sig_out_valid_d;
  logic             dly_err_q, dly_err_d;

  logic             dly_legal, load_ok, load_bad;
  logic [AW:0]      back, rd_sum;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH:0]   tap_word;

  // Tap selection uses the delay in force next cycle so a switch takes effect immediately.
  always_comb begin
    dly_legal = (dly != '0) && (dly <= DLY_W'(MAX_DELAY));
    load_bad  = dly_load && !dly_legal;
    load_ok   = dly_load && dly_legal && (dly != dly_cur_q);
    dly_cur_d = load_ok ? dly : dly_cur_q;
    wr_ptr_d  = (wr_ptr_q == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + AW'(1);
    back      = (AW+1)'(dly_cur_d) - (AW+1)'(1);
    rd_sum    = {1'b0, wr_ptr_q} + (AW+1)'(MAX_DELAY) - back;
    rd_idx    = (rd_sum >= (AW+1)'(MAX_DELAY)) ? AW'(rd_sum - (AW+1)'(MAX_DELAY)) : AW'(rd_sum);
    // A delay of one bypasses the buffer: the output register alone supplies the latency.
    tap_word  = (dly_cur_d == DLY_W'(1)) ? {sig_in_valid, sig_in} : buf_q[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DELAY_FLUSH_EN
    if (load_ok) begin
      state_d = FILL;
      cnt_d   = '0;
    end else
`endif
    if (state_q == FILL) begin
      if (cnt_q == dly_cur_q - DLY_W'(1)) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + DLY_W'(1);
      end
    end
  end

  always_comb begin
    sig_out_valid_d = (state_d == RUN) && tap_word[WIDTH];
`ifdef DELAY_FLUSH_EN
    sig_out_d       = (state_d == FILL) ? '0 : tap_word[WIDTH-1:0];
`else
    sig_out_d       = tap_word[WIDTH-1:0];
`endif
    dly_err_d       = load_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= FILL;
      cnt_q           <= '0;
      dly_cur_q       <= DLY_W'(DEFAULT_DELAY);
      wr_ptr_q        <= '0;
      sig_out_q       <= '0;
      sig_out_valid_q <= 1'b0;
      dly_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dly_cur_q       <= dly_cur_d;
      wr_ptr_q        <= wr_ptr_d;
      sig_out_q       <= sig_out_d;
      sig_out_valid_q <= sig_out_valid_d;
      dly_err_q       <= dly_err_d;
    end
  end

  // Contents are never reset; fill gating keeps stale entries from being flagged valid.
  always_ff @(posedge clk) begin
    buf_q[wr_ptr_q] <= {sig_in_valid, sig_in};
  end

  assign sig_out       = sig_out_q;
  assign sig_out_valid = sig_out_valid_q;
  assign dly_cur       = dly_cur_q;
  assign busy          = (state_q == FILL);
  assign dly_err       = dly_err_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// tb/tb_delay_line_prog.sv - randomized bench for delay_line_prog against a cycle-history reference model.
// Honours DELAY_FLUSH_EN when the design is built with it.
module tb_delay_line_prog;

  localparam int MAXD = 16;
  localparam int DEF  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sig_in = '0;
  logic       sig_in_valid = 1'b0;
  logic [4:0] dly = '0;
  logic       dly_load = 1'b0;
  logic [7:0] sig_out;
  logic       sig_out_valid;
  logic [4:0] dly_cur;
  logic       busy;
  logic       dly_err;

  delay_line_prog #(.WIDTH(8), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEF)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sig_in_valid(sig_in_valid),
    .dly(dly), .dly_load(dly_load), .sig_out(sig_out), .sig_out_valid(sig_out_valid),
    .dly_cur(dly_cur), .busy(busy), .dly_err(dly_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycle k counts from reset release; output in cycle k is the input of cycle k-cur.
  int         k;
  int         cur;
  int         run_start;
  bit         err_exp;
  logic [7:0] hd [0:8191];
  bit         hv [0:8191];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    cur = DEF;
    run_start = DEF;
    err_exp = 1'b0;
  endtask

  task automatic check_outputs();
    bit busy_e;
    int idx;
    busy_e = (k < run_start);
    idx = k - cur;
    chk("busy", 32'(busy), 32'(busy_e));
    chk("dly_cur", 32'(dly_cur), 32'(cur));
    chk("dly_err", 32'(dly_err), 32'(err_exp));
    if (busy_e || idx < 0) begin
      chk("valid_fill", 32'(sig_out_valid), 32'(0));
`ifdef DELAY_FLUSH_EN
      chk("data_flush", 32'(sig_out), 32'(0));
`endif
    end else begin
      chk("valid", 32'(sig_out_valid), 32'(hv[idx]));
      chk("data", 32'(sig_out), 32'(hd[idx]));
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic cycle(input logic [7:0] d, input bit v, input bit ld, input logic [4:0] dv);
    int cur_next;
    sig_in = d;
    sig_in_valid = v;
    dly_load = ld;
    dly = dv;
    @(negedge clk);
    check_outputs();
    hd[k] = d;
    hv[k] = v;
    cur_next = cur;
    err_exp = 1'b0;
    if (ld) begin
      if (dv == 0 || dv > MAXD) begin
        err_exp = 1'b1;
      end else if (int'(dv) != cur) begin
        cur_next = dv;
`ifdef DELAY_FLUSH_EN
        run_start = k + 1 + int'(dv);
`endif
      end
    end
    cur = cur_next;
    k++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'($urandom), 1'($urandom), 1'b0, 5'd0);
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) cycle(8'(i + 1), 1'b1, 1'b0, 5'd0);
  endtask

  initial begin
    int nbusy;
    logic [4:0] rd;
    bit ld;

    // Reset latency with a ramp; literal checks pin the first valid sample.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("rst_sig_out", 32'(sig_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_dly_cur", 32'(dly_cur), 32'(5));
    ramp(4);
    chk("ramp_c4_valid", 32'(sig_out_valid), 32'(0));
    ramp(1);
    chk("ramp_c5_data", 32'({sig_out_valid, sig_out}), 32'(9'h101));
    cycle(8'd6, 1'b1, 1'b0, 5'd0);
    chk("ramp_c6_data", 32'(sig_out), 32'(8'h02));
    for (int i = 0; i < 24; i++) cycle(8'(i + 7), 1'b1, 1'b0, 5'd0);

    // Illegal and no-op loads.
    cycle(8'h55, 1'b1, 1'b1, 5'd0);
    chk("err_dly0", 32'({dly_err, busy, dly_cur}), 32'({1'b1, 1'b0, 5'd5}));
    idle(3);
    cycle(8'h66, 1'b1, 1'b1, 5'd17);
    chk("err_dly17", 32'(dly_err), 32'(1));
    idle(3);
    cycle(8'h77, 1'b1, 1'b1, 5'd5);
    chk("noop_dly5", 32'({dly_err, busy}), 32'(0));
    idle(6);

    // Extremes, including runs long enough to wrap the pointer.
    cycle(8'h00, 1'b1, 1'b1, 5'd1);
    ramp(40);
    cycle(8'h00, 1'b1, 1'b1, 5'd16);
    ramp(60);

    // Load during fill restarts it.
    nbusy = 0;
    cycle(8'hA0, 1'b1, 1'b1, 5'd8);
    nbusy += busy;
    for (int i = 0; i < 2; i++) begin
      cycle(8'(8'hA1 + i), 1'b1, 1'b0, 5'd0);
      nbusy += busy;
    end
    cycle(8'hA3, 1'b1, 1'b1, 5'd3);
    for (int i = 0; i < 10; i++) begin
      nbusy += busy;
      cycle(8'(8'hB0 + i), 1'b1, 1'b0, 5'd0);
    end
`ifdef DELAY_FLUSH_EN
    chk("refill_busy_cycles", 32'(nbusy), 32'(6));
`else
    chk("refill_busy_cycles", 32'(nbusy), 32'(0));
`endif

    // Valid tracking at D=4.
    cycle(8'h10, 1'b1, 1'b1, 5'd4);
    idle(6);
    for (int r = 0; r < 3; r++) begin
      cycle(8'h21, 1'b1, 1'b0, 5'd0);
      cycle(8'h22, 1'b0, 1'b0, 5'd0);
      cycle(8'h23, 1'b1, 1'b0, 5'd0);
      cycle(8'h24, 1'b1, 1'b0, 5'd0);
      cycle(8'h25, 1'b0, 1'b0, 5'd0);
    end
    idle(8);

    // Random traffic with occasional legal, illegal and no-op loads.
    for (int i = 0; i < 1500; i++) begin
      ld = ($urandom_range(0, 15) == 0) && (k > MAXD + 2);
      rd = 5'($urandom_range(0, 18));
      cycle(8'($urandom), 1'($urandom), ld, rd);
    end
    idle(20);

    // Asynchronous reset mid-run with a pending load that must be discarded.
    sig_in = 8'hEE;
    sig_in_valid = 1'b1;
    dly_load = 1'b1;
    dly = 5'd8;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_outs", 32'({sig_out, sig_out_valid, dly_err}), 32'(0));
    chk("async_rst_state", 32'({busy, dly_cur}), 32'({1'b1, 5'd5}));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    ramp(5);
    chk("rerun_c5_data", 32'({sig_out_valid, sig_out}), 32'(9'h101));
    ramp(25);
    cycle(8'h00, 1'b1, 1'b1, 5'd8);
    idle(30);
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 11) == 0) && (k > MAXD + 2);
      rd = 5'($urandom_range(0, 18));
      cycle(8'($urandom), 1'($urandom), ld, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
